// File: rtl/icarus_bp_pkg.sv
// Shared types and helpers for the bimodal branch predictor: 2-bit counter
// encoding, reset value and saturating next-state.
package icarus_bp_pkg;

  localparam int unsigned CTR_WIDTH  = 2;
  localparam int unsigned PERF_WIDTH = 32;

  typedef logic [CTR_WIDTH-1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  localparam ctr_t CTR_RESET = WNT;

  // Step one toward the observed outcome, holding at the strong ends.
  function automatic ctr_t ctr_next(input ctr_t cur, input logic taken);
    ctr_t nxt;
    nxt = cur;
    if (taken) begin
      if (cur != ST) nxt = cur + CTR_WIDTH'(1);
    end else begin
      if (cur != SNT) nxt = cur - CTR_WIDTH'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bp_counter_table.sv
// Array of 2-bit direction counters: one combinational lookup port and one
// synchronous write port that also exposes the entry it is about to overwrite.
module bp_counter_table
  import icarus_bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] rd_idx,
  output logic [CTR_WIDTH-1:0]  rd_ctr,
  input  logic                  wr_en,
  input  logic [INDEX_BITS-1:0] wr_idx,
  output logic [CTR_WIDTH-1:0]  wr_cur,
  input  logic [CTR_WIDTH-1:0]  wr_ctr
);

  localparam int unsigned DEPTH = 1 << INDEX_BITS;

  ctr_t mem [DEPTH];

  // No bypass: a same-cycle write is only seen on the following cycle.
  assign rd_ctr = mem[rd_idx];
  assign wr_cur = mem[wr_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= CTR_RESET;
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch direction predictor trained by resolved comparator results.
// Optional perf counters are enabled with BP_PERF_COUNTERS_EN.
module branch_predictor
  import icarus_bp_pkg::*;
#(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned PC_WIDTH   = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  lookup_valid,
  input  logic [PC_WIDTH-1:0]   lookup_pc,
  output logic                  predict_taken,
  input  logic                  update_valid,
  input  logic [PC_WIDTH-1:0]   update_pc,
  input  logic                  update_taken,
  input  logic                  update_predicted,
  output logic                  mispredict
`ifdef BP_PERF_COUNTERS_EN
  ,
  output logic [PERF_WIDTH-1:0] branch_count,
  output logic [PERF_WIDTH-1:0] mispredict_count
`endif
);

  logic [INDEX_BITS-1:0] lookup_idx;
  logic [INDEX_BITS-1:0] update_idx;
  ctr_t                  lookup_ctr;
  ctr_t                  update_cur;
  ctr_t                  update_nxt;
  logic                  mispredict_d;
  logic                  unused_pc_bits;

  // Word-aligned PCs, untagged: distant branches may share an entry.
  assign lookup_idx = lookup_pc[INDEX_BITS+1:2];
  assign update_idx = update_pc[INDEX_BITS+1:2];
  assign unused_pc_bits = ^{lookup_pc[PC_WIDTH-1:INDEX_BITS+2], lookup_pc[1:0],
                            update_pc[PC_WIDTH-1:INDEX_BITS+2], update_pc[1:0]};

  bp_counter_table #(
    .INDEX_BITS(INDEX_BITS)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .rd_idx (lookup_idx),
    .rd_ctr (lookup_ctr),
    .wr_en  (update_valid),
    .wr_idx (update_idx),
    .wr_cur (update_cur),
    .wr_ctr (update_nxt)
  );

  assign update_nxt    = ctr_next(update_cur, update_taken);
  assign predict_taken = lookup_valid & lookup_ctr[1];

  // Judged against the carried prediction, not the table, so aliasing
  // between lookup and resolve cannot corrupt the flush decision.
  assign mispredict_d = update_valid & (update_taken ^ update_predicted);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict <= 1'b0;
    end else begin
      mispredict <= mispredict_d;
    end
  end

`ifdef BP_PERF_COUNTERS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (update_valid) branch_count     <= branch_count + PERF_WIDTH'(1);
      if (mispredict_d) mispredict_count <= mispredict_count + PERF_WIDTH'(1);
    end
  end
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: a per-entry outcome-history model is
// compared on every falling edge, plus hand-computed spot checks.
module tb_branch_predictor;

  localparam int ENTRIES = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        predict_taken;
  logic        update_valid;
  logic [31:0] update_pc;
  logic        update_taken;
  logic        update_predicted;
  logic        mispredict;
`ifdef BP_PERF_COUNTERS_EN
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic [31:0] m_br;
  logic [31:0] m_mc;
`endif

  int   errors = 0;
  int   checks = 0;
  int   m_ctr [ENTRIES];
  logic m_mp;

  branch_predictor dut (
    .clk              (clk),
    .rst              (rst),
    .lookup_valid     (lookup_valid),
    .lookup_pc        (lookup_pc),
    .predict_taken    (predict_taken),
    .update_valid     (update_valid),
    .update_pc        (update_pc),
    .update_taken     (update_taken),
    .update_predicted (update_predicted),
    .mispredict       (mispredict)
`ifdef BP_PERF_COUNTERS_EN
    ,
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % ENTRIES);
  endfunction

  // Model: each entry is a confidence level 0..3 nudged toward each outcome.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) m_ctr[i] = 1;
      m_mp = 1'b0;
`ifdef BP_PERF_COUNTERS_EN
      m_br = 0;
      m_mc = 0;
`endif
    end else begin
      m_mp = update_valid && (update_taken != update_predicted);
      if (update_valid) begin
        if (update_taken && m_ctr[idx_of(update_pc)] < 3) m_ctr[idx_of(update_pc)]++;
        if (!update_taken && m_ctr[idx_of(update_pc)] > 0) m_ctr[idx_of(update_pc)]--;
`ifdef BP_PERF_COUNTERS_EN
        m_br = m_br + 1;
        if (m_mp) m_mc = m_mc + 1;
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("predict_taken", 32'(predict_taken),
          32'(lookup_valid && (m_ctr[idx_of(lookup_pc)] >= 2)));
      chk("mispredict", 32'(mispredict), 32'(m_mp));
`ifdef BP_PERF_COUNTERS_EN
      chk("branch_count", branch_count, m_br);
      chk("mispredict_count", mispredict_count, m_mc);
`endif
    end
  end

  // Present one cycle of inputs, let the edge occur, return just after it.
  task automatic cyc(input logic lv, input logic [31:0] lpc, input logic uv,
                     input logic [31:0] upc, input logic ut, input logic up);
    lookup_valid     = lv;
    lookup_pc        = lpc;
    update_valid     = uv;
    update_pc        = upc;
    update_taken     = ut;
    update_predicted = up;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic ut, input logic up);
    cyc(1'b0, 32'h0, 1'b1, pc, ut, up);
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic exp);
    lookup_valid = 1'b1;
    lookup_pc    = pc;
    update_valid = 1'b0;
    #2;
    chk(name, 32'(predict_taken), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_pc = '0;
    update_valid = 1'b0; update_pc = '0;
    update_taken = 1'b0; update_predicted = 1'b0;
    #12 rst = 1'b0;
    @(posedge clk); #1;

    // 1: reset state
    chk("reset_mispredict", 32'(mispredict), 32'd0);
    look("reset_lookup_40", 32'h40, 1'b0);
    lookup_valid = 1'b0; lookup_pc = 32'h0; #1;
    chk("invalid_lookup", 32'(predict_taken), 32'd0);

    // 2: two mispredicted taken updates to 0x40
    upd(32'h40, 1'b1, 1'b0);
    chk("mp_after_upd1", 32'(mispredict), 32'd1);
    look("pc40_after_1", 32'h40, 1'b1);
    chk("mp_dropped", 32'(mispredict), 32'd0);
    upd(32'h40, 1'b1, 1'b0);
    chk("mp_after_upd2", 32'(mispredict), 32'd1);
    look("pc40_after_2", 32'h40, 1'b1);

    // 3: saturate high on 0x80, then walk down and saturate low
    repeat (4) upd(32'h80, 1'b1, 1'b1);
    chk("mp_correct_pred", 32'(mispredict), 32'd0);
    upd(32'h80, 1'b0, 1'b1);
    chk("mp_nt_wrong", 32'(mispredict), 32'd1);
    look("pc80_weak_t", 32'h80, 1'b1);
    upd(32'h80, 1'b0, 1'b1);
    upd(32'h80, 1'b0, 1'b0);
    look("pc80_strong_nt", 32'h80, 1'b0);
    upd(32'h80, 1'b0, 1'b0);
    upd(32'h80, 1'b1, 1'b0);
    look("pc80_no_underflow", 32'h80, 1'b0);
    upd(32'h80, 1'b1, 1'b0);
    look("pc80_back_to_wt", 32'h80, 1'b1);

    // 4: same-cycle lookup and update, no bypass
    lookup_valid = 1'b1; lookup_pc = 32'h100;
    update_valid = 1'b1; update_pc = 32'h100;
    update_taken = 1'b1; update_predicted = 1'b0;
    #2;
    chk("same_cycle_old", 32'(predict_taken), 32'd0);
    @(posedge clk); #1;
    look("same_cycle_next", 32'h100, 1'b1);

    // 5: aliasing between 0x004 and 0x104
    look("pc104_before", 32'h104, 1'b0);
    upd(32'h004, 1'b1, 1'b1);
    upd(32'h004, 1'b1, 1'b1);
    look("alias_104", 32'h104, 1'b1);
    look("pc3fc_untouched", 32'h3FC, 1'b0);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 12; i++) begin
      cyc(1'b1, 32'(i * 8), 1'b1, 32'(i * 4 + 32'h200), 1'(i % 3 != 0), 1'(i % 2));
    end

    // Mid-run reset with a mispredict pending
    upd(32'h40, 1'b0, 1'b1);
    chk("mp_before_reset", 32'(mispredict), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("reset_async_mp", 32'(mispredict), 32'd0);
    lookup_valid = 1'b1; lookup_pc = 32'h40; #1;
    chk("reset_async_pc40", 32'(predict_taken), 32'd0);
    lookup_pc = 32'h004; #1;
    chk("reset_async_pc004", 32'(predict_taken), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    look("post_reset_pc80", 32'h80, 1'b0);
    upd(32'h40, 1'b1, 1'b1);
    look("post_reset_pc40", 32'h40, 1'b1);

`ifdef BP_PERF_COUNTERS_EN
    // 6: perf counters and wrap
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    chk("perf_reset_br", branch_count, 32'd0);
    for (int i = 0; i < 10; i++) begin
      upd(32'(i * 4), 1'(i % 2), (i == 2 || i == 5 || i == 7) ? ~1'(i % 2) : 1'(i % 2));
    end
    chk("perf_branch_10", branch_count, 32'd10);
    chk("perf_mispredict_3", mispredict_count, 32'd3);
    force dut.branch_count = 32'hFFFF_FFFF;
    m_br = 32'hFFFF_FFFF;
    #1 release dut.branch_count;
    upd(32'h40, 1'b1, 1'b1);
    chk("perf_wrap", branch_count, 32'd0);
`endif

    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Bimodal branch direction predictor that is the consumer end of the branch comparator's Result.
- ID-stage fetch logic looks up a prediction by PC.
- When the comparator resolves a branch, the actual outcome trains a table of 2-bit saturating counters.
- Mispredict is flagged one cycle after resolution so the pipeline can flush and redirect.

Parameters:
- INDEX_BITS, 6, log2 of table entries (64 entries).
- PC_WIDTH, 32, width of program-counter inputs.

Ports:
- Clock  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- LookupValid  input  1  a branch is being fetched/decoded this cycle.
- LookupPC  input  PC_WIDTH  PC of the branch being looked up.
- PredictTaken  output  1  combinational prediction for LookupPC; 0 when LookupValid=0.
- UpdateValid  input  1  a branch resolved this cycle.
- UpdatePC  input  PC_WIDTH  PC of the resolved branch.
- UpdateTaken  input  1  actual outcome (comparator Result).
- UpdatePredicted  input  1  prediction that was carried down the pipe with this branch.
- Mispredict  output  1  registered; high for exactly one cycle after a wrong prediction resolves.

Behaviour:
- Index = PC[INDEX_BITS+1:2]. Word-aligned PCs; bits [1:0] ignored. No tag: aliasing is permitted.
- Table: 2^INDEX_BITS entries of 2-bit counters. 00 = strong not-taken, 01 = weak NT, 10 = weak T, 11 = strong T.
- Reset (asynchronous, any time, including mid-update):
  - all entries set to 01;
  - Mispredict = 0.
  - PredictTaken then reads 0 for every PC.
- Lookup is purely combinational, zero latency. PredictTaken = LookupValid & counter[idx][1].
- Update occurs on the rising edge when UpdateValid=1:
  - UpdateTaken=1: counter increments, saturating at 11.
  - UpdateTaken=0: counter decrements, saturating at 00.
  - UpdateValid=0: no table change.
- Mispredict register is loaded every cycle with UpdateValid & (UpdateTaken ^ UpdatePredicted). Latency is 1 cycle.
- Simultaneous lookup and update to the same index: lookup returns the pre-update value, with no bypass. The new value is visible from the next cycle.
- Back-to-back updates to the same index apply sequentially, one step per cycle.
- Mispredict does not depend on the table contents, only on UpdatePredicted. This keeps prediction-carrying consistent under aliasing.
- No stall input. The caller holds UpdateValid low when the pipeline does not resolve a branch.

Optional Feature:
- Macro: BP_PERF_COUNTERS_EN.
- Defined: adds outputs BranchCount[31:0] and MispredictCount[31:0].
  - Both reset to 0.
  - BranchCount increments on each cycle with UpdateValid=1.
  - MispredictCount increments on each cycle where the Mispredict register is being set, i.e. the same edge the register loads 1.
  - Both wrap from 0xFFFFFFFF to 0.
- Undefined: ports and logic absent; the core predictor is unchanged.

Decomposition:
- Package icarus_bp_pkg holds:
  - counter encoding constants SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11;
  - reset value WNT;
  - a function for the saturating next-state.
- One sub-module, bp_counter_table:
  - counter array with async reset;
  - one combinational read port and one synchronous write port;
  - parameterised by INDEX_BITS.
- The top level holds index extraction, next-state computation, the Mispredict register and the optional perf counters.

Test Plan:
1. Reset, then lookup PC=0x00000040 -> PredictTaken=0. Assert Reset mid-run after training -> all entries read 01 and Mispredict drops to 0 immediately.
2. Two updates to PC=0x40 with UpdateTaken=1, UpdatePredicted=0 -> Mispredict high 1 cycle after each update. Lookup 0x40 after the first update -> 1 (counter 10). After the second update -> counter 11, predict 1.
3. Four taken updates to PC=0x80, then one not-taken -> counter saturates at 11 then falls to 10; PredictTaken stays 1. Two further not-taken updates -> 00, PredictTaken=0, no underflow.
4. Same-cycle lookup and update on PC=0x100 (counter 01, taken) -> PredictTaken=0 that cycle, 1 the next cycle.
5. Aliasing: PC=0x004 and PC=0x104 map to the same index (INDEX_BITS=6). Training 0x004 taken twice -> lookup 0x104 returns 1.
6. With BP_PERF_COUNTERS_EN: 10 updates, 3 of them mispredicted -> BranchCount=10, MispredictCount=3. Preload the count to 0xFFFFFFFF via force -> the next update wraps it to 0.
